// File: rtl/gpio_port.sv
// gpio_port: WIDTH-bit general-purpose I/O port with per-bit direction,
// output latch, input synchroniser, edge-triggered interrupt flags and a
// small register interface (0 IN, 1 OUT, 2 DIR, 3 IES, 4 IE, 5 IFG).
// Optional macro GPIO_GLITCH_FILTER_EN inserts a per-bit stability filter
// between the synchroniser and the IN/edge-detect logic.
module gpio_port #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             MCLK,
  input  logic             reset,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t,
  output logic             irq
);

`ifdef GPIO_GLITCH_FILTER_EN
  localparam int ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
`else
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync_in;
  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_out, r_dir, r_ies, r_ie, r_ifg;
  logic [WIDTH-1:0] r_rdata;
  logic             r_irq;
  logic [ARM_W-1:0] r_arm;
  logic             w_armed;
  logic [WIDTH-1:0] w_rise, w_fall, w_edge;
  logic [WIDTH-1:0] w_rsel;
  logic             w_wr_ifg;

  assign w_sync_in = r_sync[SYNC_STAGES-1];

  // Input synchroniser chain; stage 0 samples the asynchronous pads.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= pad_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

`ifdef GPIO_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_CYCLES);
  logic [FCW-1:0]   r_fcnt [WIDTH];
  logic [WIDTH-1:0] r_filt;

  // Per-bit filter: adopt the synchronised value only after it has differed
  // from the filtered value for FILTER_CYCLES consecutive cycles.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_filt <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) r_fcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (w_sync_in[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILTER_CYCLES - 1)) begin
          r_filt[i] <= w_sync_in[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_in = r_filt;
`else
  assign w_in = w_sync_in;
`endif

  // Arming counter: holds off edge detection until the input pipeline has
  // flushed after reset, so a pad held high through reset raises no flag.
  always_ff @(posedge MCLK) begin
    if (reset)                r_arm <= '0;
    else if (r_arm != ARM_DONE) r_arm <= r_arm + 1'b1;
  end

  assign w_armed  = (r_arm == ARM_DONE);
  assign w_rise   = w_in & ~r_prev;
  assign w_fall   = ~w_in & r_prev;
  assign w_edge   = w_armed ? ((r_ies & w_fall) | (~r_ies & w_rise)) : '0;
  assign w_wr_ifg = wr_en && (addr == 3'd5);

  // Register file, edge history and interrupt output; hardware edges are
  // OR-ed in after a software IFG write so they win over a write of 0.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      r_out  <= '0;
      r_dir  <= '0;
      r_ies  <= '0;
      r_ie   <= '0;
      r_ifg  <= '0;
      r_prev <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          3'd1:    r_out <= wdata;
          3'd2:    r_dir <= wdata;
          3'd3:    r_ies <= wdata;
          3'd4:    r_ie  <= wdata;
          default: ;
        endcase
      end
      r_ifg  <= (w_wr_ifg ? wdata : r_ifg) | w_edge;
      r_prev <= w_in;
      r_irq  <= |(r_ifg & r_ie);
    end
  end

  // Read mux; reserved addresses return zero.
  always_comb begin
    w_rsel = '0;
    case (addr)
      3'd0:    w_rsel = w_in;
      3'd1:    w_rsel = r_out;
      3'd2:    w_rsel = r_dir;
      3'd3:    w_rsel = r_ies;
      3'd4:    w_rsel = r_ie;
      3'd5:    w_rsel = r_ifg;
      default: w_rsel = '0;
    endcase
  end

  // Registered read data; holds when no read strobe, returns pre-write value.
  always_ff @(posedge MCLK) begin
    if (reset)      r_rdata <= '0;
    else if (rd_en) r_rdata <= w_rsel;
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;
  assign pad_o = r_out;
  assign pad_t = ~r_dir;

endmodule

// File: tb/tb_gpio_port.sv
// Self-checking bench for gpio_port (WIDTH=8, SYNC_STAGES=2, FILTER_CYCLES=4).
// Filter checks compile only when GPIO_GLITCH_FILTER_EN is defined.
module tb_gpio_port;

  logic       MCLK;
  logic       reset;
  logic [2:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] pad_i;
  logic [7:0] pad_o;
  logic [7:0] pad_t;
  logic       irq;

  int total;
  int bad;

  gpio_port #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_CYCLES(4)) dut (
    .MCLK (MCLK),
    .reset(reset),
    .addr (addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wdata(wdata),
    .rdata(rdata),
    .pad_i(pad_i),
    .pad_o(pad_o),
    .pad_t(pad_t),
    .irq  (irq)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [2:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] wdata;
    logic [7:0] pad;
    logic [7:0] exp_rdata;
    logic [7:0] exp_pado;
    logic [7:0] exp_padt;
    logic       exp_irq;
  } vec_t;

  vec_t tbl [27];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic bus(input logic [2:0] a, input logic w, input logic r, input logic [7:0] d);
    addr = a; wr_en = w; rd_en = r; wdata = d;
  endtask

  task automatic idle();
    bus(3'd0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //             addr  wr    rd    wdata  pad    rdata  pad_o  pad_t  irq
    tbl[0]  = '{3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[1]  = '{3'd1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[2]  = '{3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[3]  = '{3'd3, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[4]  = '{3'd4, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[5]  = '{3'd5, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[6]  = '{3'd6, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[7]  = '{3'd7, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[8]  = '{3'd2, 1'b1, 1'b0, 8'h0F, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b0};
    tbl[9]  = '{3'd1, 1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'hF0, 1'b0};
    tbl[10] = '{3'd1, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hF0, 1'b0};
    tbl[11] = '{3'd2, 1'b0, 1'b1, 8'h00, 8'h00, 8'h0F, 8'hA5, 8'hF0, 1'b0};
    tbl[12] = '{3'd0, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h0F, 8'hA5, 8'hF0, 1'b0};
    tbl[13] = '{3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hF0, 1'b0};
    tbl[14] = '{3'd6, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'hA5, 8'hF0, 1'b0};
    tbl[15] = '{3'd6, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hF0, 1'b0};
    tbl[16] = '{3'd1, 1'b1, 1'b1, 8'h3C, 8'h00, 8'hA5, 8'h3C, 8'hF0, 1'b0};
    tbl[17] = '{3'd1, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'hF0, 1'b0};
    tbl[18] = '{3'd4, 1'b1, 1'b0, 8'h01, 8'h00, 8'h3C, 8'h3C, 8'hF0, 1'b0};
    tbl[19] = '{3'd5, 1'b1, 1'b0, 8'hF0, 8'h00, 8'h3C, 8'h3C, 8'hF0, 1'b0};
    tbl[20] = '{3'd5, 1'b0, 1'b1, 8'h00, 8'h00, 8'hF0, 8'h3C, 8'hF0, 1'b0};
    tbl[21] = '{3'd5, 1'b1, 1'b0, 8'h00, 8'h00, 8'hF0, 8'h3C, 8'hF0, 1'b0};
    tbl[22] = '{3'd5, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hF0, 1'b0};
    tbl[23] = '{3'd3, 1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h3C, 8'hF0, 1'b0};
    tbl[24] = '{3'd5, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hF0, 1'b0};
    tbl[25] = '{3'd3, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hF0, 1'b0};
    tbl[26] = '{3'd4, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 8'h3C, 8'hF0, 1'b0};

    // Reset hold
    reset = 1'b1;
    pad_i = 8'h00;
    idle();
    tick();
    tick();
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_pad_o", pad_o, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_rdata", rdata, 8'h00);

    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Register access table
    for (int i = 0; i < 27; i++) begin
      bus(tbl[i].addr, tbl[i].wr, tbl[i].rd, tbl[i].wdata);
      pad_i = tbl[i].pad;
      tick();
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("v%0d_pad_o", i), pad_o, tbl[i].exp_pado);
      chk($sformatf("v%0d_pad_t", i), pad_t, tbl[i].exp_padt);
      chk($sformatf("v%0d_irq", i), {7'd0, irq}, {7'd0, tbl[i].exp_irq});
    end

    // Rising edge on bit 0 (IE=01, IES=00): IN after 2, IFG after 3, irq after 4
    pad_i = 8'h01;
    bus(3'd0, 1'b0, 1'b1, 8'h00);
    tick(); chk("rise_in_e0", rdata, 8'h00);
    tick(); chk("rise_in_e1", rdata, 8'h00);
    tick(); chk("rise_in_e2", rdata, 8'h01);
    chk("rise_irq_e2", {7'd0, irq}, 8'h00);
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("rise_ifg_e3", rdata, 8'h01);
    chk("rise_irq_e3", {7'd0, irq}, 8'h01);
    bus(3'd5, 1'b1, 1'b0, 8'h00);
    tick(); chk("clr_irq_e4", {7'd0, irq}, 8'h01);
    idle();
    tick(); chk("clr_irq_e5", {7'd0, irq}, 8'h00);
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("clr_ifg", rdata, 8'h00);

    // Falling-edge select on bit 3; rising edge must not flag
    bus(3'd3, 1'b1, 1'b0, 8'h08);
    tick();
    bus(3'd5, 1'b1, 1'b0, 8'h80);
    pad_i = 8'h09;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("ies_rise_ifg", rdata, 8'h80);
    idle();
    pad_i = 8'h01;
    tick();
    tick();
    bus(3'd5, 1'b1, 1'b0, 8'h00);
    tick();
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("hw_priority_ifg", rdata, 8'h08);
    chk("hw_priority_irq", {7'd0, irq}, 8'h00);

    // Mid-operation reset with pads held high through release
    pad_i = 8'hFF;
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst2_pad_t", pad_t, 8'hFF);
    chk("rst2_pad_o", pad_o, 8'h00);
    chk("rst2_rdata", rdata, 8'h00);
    chk("rst2_irq", {7'd0, irq}, 8'h00);
    reset = 1'b0;
    bus(3'd4, 1'b1, 1'b0, 8'hFF);
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("arm_irq_%0d", i), {7'd0, irq}, 8'h00);
    end
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("arm_ifg", rdata, 8'h00);
    bus(3'd0, 1'b0, 1'b1, 8'h00);
    tick(); chk("arm_in", rdata, 8'hFF);

`ifdef GPIO_GLITCH_FILTER_EN
    // 3-cycle glitch low on bit 2 must be rejected
    idle();
    pad_i = 8'hFB;
    tick(); tick(); tick();
    pad_i = 8'hFF;
    for (int i = 0; i < 10; i++) tick();
    bus(3'd0, 1'b0, 1'b1, 8'h00);
    tick(); chk("glitch_in", rdata, 8'hFF);
    bus(3'd5, 1'b0, 1'b1, 8'h00);
    tick(); chk("glitch_ifg", rdata, 8'h00);
    // Stable change: IN updates 6 cycles after the pad change
    bus(3'd0, 1'b0, 1'b1, 8'h00);
    pad_i = 8'hFB;
    for (int i = 0; i < 6; i++) tick();
    chk("filt_in_e5", rdata, 8'hFF);
    tick(); chk("filt_in_e6", rdata, 8'hFB);
`endif

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
